// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants, the sequencer state type and the write-port priority
//   helper for the multi-port integer register file.
//   No ports (package).
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Upper bound on write ports handled by the priority helper; NWR must not
  // exceed this value.
  localparam int MAX_WR = 8;

  typedef enum logic {CLEAR, READY} rf_state_e;

  // Index of the highest set bit in a write-port hit vector, so that the
  // highest-numbered port wins when several ports target the same register.
  // Returns 0 when no bit is set; callers gate on |hits.
  function automatic int unsigned hi_port(input logic [MAX_WR-1:0] hits);
    hi_port = 0;
    for (int k = 0; k < MAX_WR; k++) begin
      if (hits[k]) hi_port = k;
    end
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Per-register busy bits. Decode marks a destination pending; writeback
//   clears it. Register 0 is never busy.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears all bits)
//   i_ready         register file has finished its clear sequence
//   i_wr_q          per-port qualified write (enable, nonzero addr, ready)
//   i_wr_addr       write addresses, port p at [p*AW +: AW]
//   i_sb_set_en     mark i_sb_set_addr as pending
//   i_sb_set_addr   destination register to mark
//   i_rd_addr       read addresses, port i at [i*AW +: AW]
//   i_rd_mask       per-read-port busy mask (register being bypass-written)
//   o_rd_busy       busy bit looked up for each read address
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ready,
  input  logic [NWR-1:0]    i_wr_q,
  input  logic [NWR*AW-1:0] i_wr_addr,
  input  logic              i_sb_set_en,
  input  logic [AW-1:0]     i_sb_set_addr,
  input  logic [NRD*AW-1:0] i_rd_addr,
  input  logic [NRD-1:0]    i_rd_mask,
  output logic [NRD-1:0]    o_rd_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Clears are applied before the set so that a newer producer marked in
  // the same cycle as an older producer's writeback keeps the bit pending.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int p = 0; p < NWR; p++) begin
      if (i_wr_q[p]) w_busy_nxt[i_wr_addr[p*AW +: AW]] = 1'b0;
    end
    if (i_ready && i_sb_set_en && (i_sb_set_addr != '0)) begin
      w_busy_nxt[i_sb_set_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  always_comb begin
    o_rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      o_rd_busy[i] = i_ready && !i_rd_mask[i] && r_busy[i_rd_addr[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Multi-port integer register file: NRD combinational read ports, NWR
//   synchronous write ports, busy scoreboard, and a clear sequencer that
//   zeroes one entry per cycle after reset.
//   Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding in
//   the same cycle, with busy masked on forwarded reads).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   o_init_done     high once every entry has been cleared
//   i_wr_en         per-port write enable
//   i_wr_addr       write addresses, port p at [p*AW +: AW]
//   i_wr_data       write data, port p at [p*XLEN +: XLEN]
//   i_rd_addr       read addresses, port i at [i*AW +: AW]
//   o_rd_data       read data (combinational), port i at [i*XLEN +: XLEN]
//   o_rd_busy       scoreboard busy bit per read address
//   i_sb_set_en     mark i_sb_set_addr as pending
//   i_sb_set_addr   destination register to mark
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                o_init_done,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  input  logic [NRD*AW-1:0]   i_rd_addr,
  output logic [NRD*XLEN-1:0] o_rd_data,
  output logic [NRD-1:0]      o_rd_busy,
  input  logic                i_sb_set_en,
  input  logic [AW-1:0]       i_sb_set_addr
);

  rf_state_e       r_state, w_state_nxt;
  logic [AW-1:0]   r_clr_cnt, w_clr_cnt_nxt;
  logic [XLEN-1:0] r_mem [NREGS];
  logic            w_ready;
  logic [NWR-1:0]  w_wr_q;
  logic [NRD-1:0]  w_byp_mask;

  assign w_ready     = (r_state == READY);
  assign o_init_done = w_ready;

  // Clear sequencer: walk every entry once, then stay READY until reset.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    if (r_state == CLEAR) begin
      w_clr_cnt_nxt = r_clr_cnt + 1'b1;
      if (r_clr_cnt == AW'(NREGS - 1)) w_state_nxt = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // A write only counts once the array is ready, outside reset, and not to x0.
  always_comb begin
    w_wr_q = '0;
    for (int p = 0; p < NWR; p++) begin
      w_wr_q[p] = i_wr_en[p] && !rst && w_ready && (i_wr_addr[p*AW +: AW] != '0);
    end
  end

  // The array has no reset of its own; the sequencer zeroes it instead.
  // Ports are visited in ascending order so the highest index lands last.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == CLEAR) begin
        r_mem[r_clr_cnt] <= '0;
      end else begin
        for (int p = 0; p < NWR; p++) begin
          if (w_wr_q[p]) r_mem[i_wr_addr[p*AW +: AW]] <= i_wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [MAX_WR-1:0] w_hits [NRD];

  always_comb begin
    w_byp_mask = '0;
    for (int i = 0; i < NRD; i++) begin
      w_hits[i] = '0;
      for (int p = 0; p < NWR; p++) begin
        w_hits[i][p] = w_wr_q[p] && (i_wr_addr[p*AW +: AW] == i_rd_addr[i*AW +: AW]);
      end
      w_byp_mask[i] = |w_hits[i];
    end
  end
`else
  assign w_byp_mask = '0;
`endif

  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if (w_ready && (i_rd_addr[i*AW +: AW] != '0)) begin
        o_rd_data[i*XLEN +: XLEN] = r_mem[i_rd_addr[i*AW +: AW]];
      end
`ifdef REGFILE_BYPASS_EN
      if (w_byp_mask[i]) begin
        o_rd_data[i*XLEN +: XLEN] = i_wr_data[hi_port(w_hits[i])*XLEN +: XLEN];
      end
`endif
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .i_ready       (w_ready),
    .i_wr_q        (w_wr_q),
    .i_wr_addr     (i_wr_addr),
    .i_sb_set_en   (i_sb_set_en),
    .i_sb_set_addr (i_sb_set_addr),
    .i_rd_addr     (i_rd_addr),
    .i_rd_mask     (w_byp_mask),
    .o_rd_busy     (o_rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
//   Self-checking bench for regfile_mp with default parameters
//   (XLEN=32, NREGS=32, NRD=2, NWR=2). Expected values follow
//   REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        initDone;
  logic [1:0]  wrEn;
  logic [9:0]  wrAddr;
  logic [63:0] wrData;
  logic [9:0]  rdAddr;
  logic [63:0] rdData;
  logic [1:0]  rdBusy;
  logic        sbSetEn;
  logic [4:0]  sbSetAddr;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    logic [1:0]  wrEn;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        sbSet;
    logic [4:0]  sbAddr;
    logic [31:0] expRd0;
    logic [31:0] expRd1;
    logic        expBusy0;
    logic        expBusy1;
  } vec_t;

  vec_t vectors [8];

  regfile_mp dut (
    .clk           (clk),
    .rst           (rst),
    .o_init_done   (initDone),
    .i_wr_en       (wrEn),
    .i_wr_addr     (wrAddr),
    .i_wr_data     (wrData),
    .i_rd_addr     (rdAddr),
    .o_rd_data     (rdData),
    .o_rd_busy     (rdBusy),
    .i_sb_set_en   (sbSetEn),
    .i_sb_set_addr (sbSetAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input vec_t v);
    wrEn      = v.wrEn;
    wrAddr    = {v.wa1, v.wa0};
    wrData    = {v.wd1, v.wd0};
    rdAddr    = {v.ra1, v.ra0};
    sbSetEn   = v.sbSet;
    sbSetAddr = v.sbAddr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Counts posedges until init_done rises; returns 0 if it never does.
  task automatic waitInitDone(output int cycles);
    cycles = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (initDone) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic idleInputs();
    wrEn = '0; wrAddr = '0; wrData = '0; rdAddr = '0; sbSetEn = 1'b0; sbSetAddr = '0;
  endtask

  initial begin
    int cyc;

    // wrEn  wa0    wd0           wa1    wd1           ra0    ra1    set   sbA    expRd0        expRd1        b0    b1
    vectors[0] = '{2'b11, 5'd1,  32'hA5A5A5A5, 5'd2,  32'h12345678, 5'd4,  5'd6,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
    vectors[1] = '{2'b11, 5'd7,  32'h11111111, 5'd7,  32'h22222222, 5'd1,  5'd2,  1'b0, 5'd0,  32'hA5A5A5A5, 32'h12345678, 1'b0, 1'b0};
    vectors[2] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd7,  5'd1,  1'b1, 5'd9,  32'h22222222, 32'hA5A5A5A5, 1'b0, 1'b0};
    vectors[3] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd2,  1'b1, 5'd10, 32'h0,        32'h12345678, 1'b1, 1'b0};
    vectors[4] = '{2'b11, 5'd12, 32'hCCCC0000, 5'd11, 32'hBBBB0000, 5'd10, 5'd9,  1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b1};
    vectors[5] = '{2'b01, 5'd10, 32'h0A0A0A0A, 5'd0,  32'h0,        5'd11, 5'd12, 1'b0, 5'd0,  32'hBBBB0000, 32'hCCCC0000, 1'b0, 1'b0};
    vectors[6] = '{2'b10, 5'd0,  32'h0,        5'd0,  32'hFFFFFFFF, 5'd10, 5'd9,  1'b1, 5'd0,  32'h0A0A0A0A, 32'h0,        1'b0, 1'b1};
    vectors[7] = '{2'b01, 5'd3,  32'h0BAD0003, 5'd0,  32'h0,        5'd0,  5'd9,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b1};

    idleInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Reset clear: writes and sets to x5 are attempted throughout CLEAR.
    @(negedge clk);
    rst = 1'b0;
    wrEn = 2'b01; wrAddr = {5'd0, 5'd5}; wrData = {32'h0, 32'h0000DEAD};
    sbSetEn = 1'b1; sbSetAddr = 5'd5; rdAddr = {5'd5, 5'd5};
    #1;
    checkOutput("clear init_done low", 32'(initDone), 32'h0);
    checkOutput("clear rd x5", rdData[31:0], 32'h0);
    checkOutput("clear busy x5", 32'(rdBusy[0]), 32'h0);
    waitInitDone(cyc);
    idleInputs();
    rdAddr = {5'd5, 5'd5};
    #1;
    checkOutput("init latency", 32'(cyc), 32'd32);
    checkOutput("ready rd x5", rdData[31:0], 32'h0);
    checkOutput("ready busy x5", 32'(rdBusy[0]), 32'h0);

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus(vectors[i]);
      #1;
      checkOutput($sformatf("vec%0d rd0", i), rdData[31:0], vectors[i].expRd0);
      checkOutput($sformatf("vec%0d rd1", i), rdData[63:32], vectors[i].expRd1);
      checkOutput($sformatf("vec%0d busy0", i), 32'(rdBusy[0]), 32'(vectors[i].expBusy0));
      checkOutput($sformatf("vec%0d busy1", i), 32'(rdBusy[1]), 32'(vectors[i].expBusy1));
    end

    $display("[TB] bypass and x0 sequence");
    @(negedge clk);
    idleInputs();
    wrEn = 2'b11; wrAddr = {5'd0, 5'd3}; wrData = {32'hFFFFFFFF, 32'hCAFEF00D};
    rdAddr = {5'd0, 5'd3}; sbSetEn = 1'b1; sbSetAddr = 5'd0;
    #1;
    checkOutput("bypass x3 same cycle", rdData[31:0], BYP ? 32'hCAFEF00D : 32'h0BAD0003);
    checkOutput("x0 write rd", rdData[63:32], 32'h0);
    checkOutput("x0 write busy", 32'(rdBusy[1]), 32'h0);
    @(negedge clk);
    idleInputs();
    rdAddr = {5'd0, 5'd3};
    #1;
    checkOutput("bypass x3 next cycle", rdData[31:0], 32'hCAFEF00D);
    checkOutput("x0 after write rd", rdData[63:32], 32'h0);
    checkOutput("x0 after set busy", 32'(rdBusy[1]), 32'h0);

    // Same-address dual write seen through the bypass path.
    @(negedge clk);
    wrEn = 2'b11; wrAddr = {5'd13, 5'd13}; wrData = {32'h00000002, 32'h00000001};
    rdAddr = {5'd0, 5'd13};
    #1;
    checkOutput("dual write x13 same cycle", rdData[31:0], BYP ? 32'h00000002 : 32'h0);
    @(negedge clk);
    idleInputs();
    rdAddr = {5'd0, 5'd13};
    #1;
    checkOutput("dual write x13 next cycle", rdData[31:0], 32'h00000002);

    $display("[TB] scoreboard priority sequence");
    @(negedge clk);
    wrEn = 2'b01; wrAddr = {5'd0, 5'd9}; wrData = {32'h0, 32'h00000099};
    sbSetEn = 1'b1; sbSetAddr = 5'd9; rdAddr = {5'd0, 5'd9};
    #1;
    checkOutput("sb write+set x9 busy", 32'(rdBusy[0]), BYP ? 32'h0 : 32'h1);
    checkOutput("sb write+set x9 rd", rdData[31:0], BYP ? 32'h00000099 : 32'h0);
    @(negedge clk);
    idleInputs();
    rdAddr = {5'd0, 5'd9};
    #1;
    checkOutput("sb set wins busy", 32'(rdBusy[0]), 32'h1);
    checkOutput("sb set wins rd", rdData[31:0], 32'h00000099);
    @(negedge clk);
    wrEn = 2'b10; wrAddr = {5'd9, 5'd0}; wrData = {32'h0000009A, 32'h0};
    rdAddr = {5'd4, 5'd4};
    #1;
    checkOutput("sb clear write rd x4", rdData[31:0], 32'h0);
    @(negedge clk);
    idleInputs();
    rdAddr = {5'd9, 5'd0};
    #1;
    checkOutput("sb cleared busy", 32'(rdBusy[1]), 32'h0);
    checkOutput("sb cleared rd", rdData[63:32], 32'h0000009A);

    $display("[TB] reset mid-clear sequence");
    @(negedge clk);
    rst = 1'b1;
    sbSetEn = 1'b1; sbSetAddr = 5'd20;
    @(negedge clk);
    rst = 1'b0;
    sbSetEn = 1'b0;
    #1;
    checkOutput("rst init_done low", 32'(initDone), 32'h0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    waitInitDone(cyc);
    rdAddr = {5'd20, 5'd9};
    #1;
    checkOutput("restart latency", 32'(cyc), 32'd32);
    checkOutput("restart rd x9", rdData[31:0], 32'h0);
    checkOutput("restart busy x20", 32'(rdBusy[1]), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the pipelined RISC-V core. It has NRD asynchronous read ports, NWR synchronous write ports, an optional write-to-read bypass, and a per-register busy scoreboard. After reset, a clear sequencer zeroes the array one entry per cycle, so no multi-entry reset fan-out is required. The block sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >=2)
NRD, 2, number of read ports
NWR, 2, number of write ports
AW, $clog2(NREGS), address width (derived, not overridable)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
init_done  out  1  high once the clear sequence has finished
wr_en  in  NWR  per-port write enable
wr_addr  in  NWR*AW  write addresses, port i at [i*AW +: AW]
wr_data  in  NWR*XLEN  write data, port i at [i*XLEN +: XLEN]
rd_addr  in  NRD*AW  read addresses
rd_data  out  NRD*XLEN  read data, combinational
rd_busy  out  NRD  scoreboard busy bit for each read address
sb_set_en  in  1  mark a destination register as pending
sb_set_addr  in  AW  destination register to mark

Behaviour:
- Reset and clear FSM:
  - States are CLEAR and READY.
  - rst=1 forces CLEAR, clr_cnt=0, all busy bits=0, init_done=0.
  - In CLEAR, entry clr_cnt is written 0 each cycle and clr_cnt increments.
  - At clr_cnt==NREGS-1 the FSM goes to READY and init_done=1 on the next cycle.
  - Clear latency is exactly NREGS cycles after rst deasserts.
  - rst asserted mid-clear restarts from entry 0.
- During CLEAR:
  - wr_en is ignored and sb_set_en is ignored.
  - rd_data reads 0 and rd_busy reads 0.
- Register 0:
  - Always reads 0, and writes to it are discarded.
  - It is never marked busy; sb_set on address 0 is ignored.
- Write:
  - On posedge, for each port with wr_en=1 and addr!=0, the entry takes wr_data.
  - Same address on several ports: the highest port index wins.
- Read:
  - rd_data[i] = array[rd_addr[i]], combinational, with no clock latency.
- Scoreboard:
  - Any qualifying write clears busy[wr_addr].
  - sb_set_en sets busy[sb_set_addr].
  - Set and clear of the same address in the same cycle: set wins, because a newer producer is in flight.
  - rd_busy[i] = busy[rd_addr[i]], masked to 0 while that register is being bypass-written in the same cycle (only when the bypass is enabled).
- No error handling; out-of-range addresses cannot occur because NREGS is a power of 2.

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - If any port writes rd_addr[i] (nonzero) in the current cycle, rd_data[i] returns that wr_data, using the highest-index port on conflict.
  - rd_busy[i] is masked as described above.
- Undefined:
  - rd_data returns the pre-write array value; the new value is visible the next cycle.
  - rd_busy is unmasked.

Decomposition:
- Package regfile_pkg holds:
  - XLEN_DEF and NREGS_DEF constants
  - typedef enum logic {CLEAR, READY} rf_state_e
  - a helper function for the highest-priority write-port select
- One natural sub-module, regfile_scoreboard, containing the busy vector, set/clear priority and read-port lookup, parametrised by NREGS/NRD/NWR.
- The array, clear FSM and bypass muxing stay in the top level.

Test Plan:
- Reset clear: pulse rst, then hold wr_en=1 to x5 with 0xDEAD during CLEAR -> init_done rises exactly 32 cycles after rst falls, and x5 reads 0.
- Dual write same address: port0 writes x7=0x11111111 and port1 writes x7=0x22222222 in the same cycle -> the next-cycle read of x7 is 0x22222222.
- Bypass: write x3=0xCAFEF00D while reading x3 in the same cycle -> with REGFILE_BYPASS_EN defined, rd_data=0xCAFEF00D that cycle; undefined, the old value that cycle and 0xCAFEF00D the next.
- Scoreboard priority: sb_set x9, then next cycle write x9 plus sb_set x9 -> busy[9] stays 1; a following write with no set -> busy[9]=0.
- x0 hardwire: write 0xFFFFFFFF to x0 and sb_set x0 -> rd_data=0 and rd_busy=0.
- Reset mid-clear: assert rst at clr_cnt=10 -> init_done is delayed to 32 cycles after the second rst deassertion.
